// File: rtl/sb_pkg.sv
// Shared widths, LAT_UNKNOWN derivation and source-index unpacking for the hazard scoreboard.
package sb_pkg;

    localparam int SB_REGFILE_LEN_DEF = 6;
    localparam int SB_LAT_WIDTH_DEF   = 4;
    localparam int SB_NUM_SRC_DEF     = 3;

    // Upper bounds for the unpack helper; the top casts its packed bus into this width.
    localparam int SB_MAX_REG_LEN = 16;
    localparam int SB_MAX_BUS     = 128;

    function automatic int lat_unknown(input int width);
        return (1 << width) - 1;
    endfunction

    function automatic logic [SB_MAX_REG_LEN-1:0] src_idx(
        input logic [SB_MAX_BUS-1:0] bus,
        input int                    slot,
        input int                    len
    );
        logic [SB_MAX_BUS-1:0] shifted;
        shifted = bus >> (slot * len);
        return shifted[SB_MAX_REG_LEN-1:0] &
               ((SB_MAX_REG_LEN'(1) << len) - SB_MAX_REG_LEN'(1));
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One register's latency counter: load beats clear beats hold-gated decrement; LAT_UNKNOWN never decrements.
// Single-cycle update, no backpressure of its own.
module sb_entry
    import sb_pkg::*;
#(
    parameter int LAT_WIDTH = SB_LAT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 load,
    input  logic [LAT_WIDTH-1:0] load_val,
    input  logic                 clear,
    output logic [LAT_WIDTH-1:0] cnt
);

    localparam logic [LAT_WIDTH-1:0] LAT_UNKNOWN = LAT_WIDTH'(lat_unknown(LAT_WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold && cnt != '0 && cnt != LAT_UNKNOWN) begin
            cnt <= cnt - LAT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW/WAW issue scoreboard; stall is combinational, counter updates land next edge, hold freezes counters.
// Optional SB_WB_BYPASS_EN: a same-cycle wb to a hazard register suppresses that hazard.
module hazard_scoreboard
    import sb_pkg::*;
#(
    parameter int REGFILE_LEN = SB_REGFILE_LEN_DEF,
    parameter int LAT_WIDTH   = SB_LAT_WIDTH_DEF,
    parameter int NUM_SRC     = SB_NUM_SRC_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic                          issue_valid,
    input  logic [REGFILE_LEN-1:0]        issue_rd,
    input  logic                          issue_reg_write,
    input  logic [LAT_WIDTH-1:0]          issue_lat,
    input  logic [NUM_SRC*REGFILE_LEN-1:0] issue_rs,
    input  logic [NUM_SRC-1:0]            issue_rs_used,
    input  logic                          squash,
    input  logic                          wb_valid,
    input  logic [REGFILE_LEN-1:0]        wb_rd,
    output logic                          stall,
    output logic                          issue_accept,
    output logic [(1<<REGFILE_LEN)-1:0]   pending_mask,
    output logic                          busy_unknown
);

    localparam int NREG = 1 << REGFILE_LEN;
    localparam logic [LAT_WIDTH-1:0] LAT_UNKNOWN = LAT_WIDTH'(lat_unknown(LAT_WIDTH));

    logic [LAT_WIDTH-1:0]   cnt [NREG];
    logic [REGFILE_LEN-1:0] rs  [NUM_SRC];
    logic [NUM_SRC-1:0]     src_byp;
    logic                   rd_byp;
    logic                   raw;
    logic                   waw;
    logic                   do_load;
    logic                   last_vld;
    logic [REGFILE_LEN-1:0] last_rd;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            rs[i] = REGFILE_LEN'(src_idx(SB_MAX_BUS'(issue_rs), i, REGFILE_LEN));
        end
    end

`ifdef SB_WB_BYPASS_EN
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_byp[i] = wb_valid && (wb_rd == rs[i]);
        end
        rd_byp = wb_valid && (wb_rd == issue_rd);
    end
`else
    assign src_byp = '0;
    assign rd_byp  = 1'b0;
`endif

    // Index 0 never loads, so cnt[0] stays zero and needs no special case here.
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (issue_rs_used[i] && cnt[rs[i]] != '0 && !src_byp[i]) begin
                raw = 1'b1;
            end
        end
        raw = raw && issue_valid;
        waw = issue_reg_write && !rd_byp &&
              (cnt[issue_rd] == LAT_UNKNOWN || cnt[issue_rd] > issue_lat);
    end

    assign stall        = raw || waw;
    assign issue_accept = issue_valid && !stall && !hold;
    assign do_load      = issue_accept && issue_reg_write &&
                          issue_rd != '0 && issue_lat != '0;

    // Only tracked writes are recorded, so a squash never clears an older producer's counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld <= 1'b0;
            last_rd  <= '0;
        end else begin
            last_vld <= do_load;
            last_rd  <= issue_rd;
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_entry
        logic load;
        logic clear;

        assign load  = do_load && (issue_rd == REGFILE_LEN'(r));
        assign clear = (wb_valid && wb_rd == REGFILE_LEN'(r)) ||
                       (squash && last_vld && last_rd == REGFILE_LEN'(r));

        sb_entry #(
            .LAT_WIDTH (LAT_WIDTH)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .hold     (hold),
            .load     (load),
            .load_val (issue_lat),
            .clear    (clear),
            .cnt      (cnt[r])
        );

        assign pending_mask[r] = (cnt[r] != '0);
    end

    always_comb begin
        busy_unknown = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (cnt[r] == LAT_UNKNOWN) begin
                busy_unknown = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard (default parameters; honours SB_WB_BYPASS_EN).
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        issue_valid;
    logic [5:0]  issue_rd;
    logic        issue_reg_write;
    logic [3:0]  issue_lat;
    logic [17:0] issue_rs;
    logic [2:0]  issue_rs_used;
    logic        squash;
    logic        wb_valid;
    logic [5:0]  wb_rd;
    logic        stall;
    logic        issue_accept;
    logic [63:0] pending_mask;
    logic        busy_unknown;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .hold            (hold),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_reg_write (issue_reg_write),
        .issue_lat       (issue_lat),
        .issue_rs        (issue_rs),
        .issue_rs_used   (issue_rs_used),
        .squash          (squash),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .stall           (stall),
        .issue_accept    (issue_accept),
        .pending_mask    (pending_mask),
        .busy_unknown    (busy_unknown)
    );

    // Expected {stall, issue_accept, pending, busy_unknown}; pidx < 0 means "any bit of pending_mask".
    typedef struct {
        string      nm;
        logic [3:0] ex;
        int         pidx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef SB_WB_BYPASS_EN
    localparam logic [3:0] EX_RAW7_WB = 4'b0111;
`else
    localparam logic [3:0] EX_RAW7_WB = 4'b1011;
`endif

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic       pend;
            logic [3:0] act;
            e    = q.pop_front();
            pend = (e.pidx < 0) ? |pending_mask : pending_mask[e.pidx];
            act  = {stall, issue_accept, pend, busy_unknown};
            checks++;
            if (act !== e.ex) begin
                errors++;
                $display("FAIL %s: stall/accept/pending/busy_unknown got %b want %b",
                         e.nm, act, e.ex);
            end
        end
    end

    task automatic drive(input logic v, input logic [5:0] rd, input logic rw, input logic [3:0] lat,
                         input logic [17:0] rs, input logic [2:0] used, input logic h,
                         input logic sq, input logic wv, input logic [5:0] wrd);
        issue_valid     = v;
        issue_rd        = rd;
        issue_reg_write = rw;
        issue_lat       = lat;
        issue_rs        = rs;
        issue_rs_used   = used;
        hold            = h;
        squash          = sq;
        wb_valid        = wv;
        wb_rd           = wrd;
    endtask

    task automatic cyc(input string nm, input logic v, input logic [5:0] rd, input logic rw,
                       input logic [3:0] lat, input logic [17:0] rs, input logic [2:0] used,
                       input logic h, input logic sq, input logic wv, input logic [5:0] wrd,
                       input int pidx, input logic [3:0] ex);
        drive(v, rd, rw, lat, rs, used, h, sq, wv, wrd);
        q.push_back('{nm, ex, pidx});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        cyc("rst_idle",   0, 0, 0, 0, 18'd0, 3'b000, 0, 0, 0, 0, -1, 4'b0000);
        // Producer rd=5 lat=2; consumer on rs1 stalls two cycles.
        cyc("iss5",       1, 5, 1, 2, 18'd0, 3'b000, 0, 0, 0, 0, 5, 4'b0100);
        cyc("raw5_a",     1, 0, 0, 0, {12'd0, 6'd5}, 3'b001, 0, 0, 0, 0, 5, 4'b1010);
        cyc("raw5_b",     1, 0, 0, 0, {12'd0, 6'd5}, 3'b001, 0, 0, 0, 0, 5, 4'b1010);
        cyc("raw5_ok",    1, 0, 0, 0, {12'd0, 6'd5}, 3'b001, 0, 0, 0, 0, 5, 4'b0100);
        // Unknown latency on rd=7, consumer via rs3 slot, released by wb.
        cyc("iss7unk",    1, 7, 1, 15, 18'd0, 3'b000, 0, 0, 0, 0, 7, 4'b0100);
        cyc("raw7_a",     1, 0, 0, 0, {6'd7, 12'd0}, 3'b100, 0, 0, 0, 0, 7, 4'b1011);
        cyc("raw7_b",     1, 0, 0, 0, {6'd7, 12'd0}, 3'b100, 0, 0, 0, 0, 7, 4'b1011);
        cyc("raw7_wb",    1, 0, 0, 0, {6'd7, 12'd0}, 3'b100, 0, 0, 1, 7, 7, EX_RAW7_WB);
        cyc("raw7_after", 1, 0, 0, 0, {6'd7, 12'd0}, 3'b100, 0, 0, 0, 0, 7, 4'b0100);
        // Hold freezes the rd=3 counter at 2.
        cyc("iss3",       1, 3, 1, 2, 18'd0, 3'b000, 0, 0, 0, 0, 3, 4'b0100);
        for (int k = 0; k < 3; k++)
            cyc("hold3",  1, 0, 0, 0, {12'd0, 6'd3}, 3'b001, 1, 0, 0, 0, 3, 4'b1010);
        cyc("hold_off_a", 1, 0, 0, 0, {12'd0, 6'd3}, 3'b001, 0, 0, 0, 0, 3, 4'b1010);
        cyc("hold_off_b", 1, 0, 0, 0, {12'd0, 6'd3}, 3'b001, 0, 0, 0, 0, 3, 4'b1010);
        cyc("hold_rel",   1, 0, 0, 0, {12'd0, 6'd3}, 3'b001, 0, 0, 0, 0, 3, 4'b0100);
        // Squash the rd=9 producer the cycle after issue.
        cyc("iss9",       1, 9, 1, 3, 18'd0, 3'b000, 0, 0, 0, 0, 9, 4'b0100);
        cyc("sq9",        0, 0, 0, 0, 18'd0, 3'b000, 0, 1, 0, 0, 9, 4'b0010);
        cyc("dep9",       1, 0, 0, 0, {12'd0, 6'd9}, 3'b001, 0, 0, 0, 0, 9, 4'b0100);
        // WAW against an unknown-latency rd=4, then register 0 behaviour.
        cyc("iss4unk",    1, 4, 1, 15, 18'd0, 3'b000, 0, 0, 0, 0, 4, 4'b0100);
        cyc("waw4",       1, 4, 1, 1, 18'd0, 3'b000, 0, 0, 0, 0, 4, 4'b1011);
        cyc("wb4",        0, 0, 0, 0, 18'd0, 3'b000, 0, 0, 1, 4, 4, 4'b0011);
        cyc("iss0",       1, 0, 1, 2, 18'd0, 3'b000, 0, 0, 0, 0, 0, 4'b0100);
        cyc("raw0",       1, 0, 0, 0, 18'd0, 3'b001, 0, 0, 0, 0, -1, 4'b0100);
        // Squash with no valid record must not clear rd=6.
        cyc("iss6",       1, 6, 1, 3, 18'd0, 3'b000, 0, 0, 0, 0, 6, 4'b0100);
        cyc("idle6",      0, 0, 0, 0, 18'd0, 3'b000, 0, 0, 0, 0, 6, 4'b0010);
        cyc("sq_noop",    0, 0, 0, 0, 18'd0, 3'b000, 0, 1, 0, 0, 6, 4'b0010);
        cyc("after_noop", 0, 0, 0, 0, 18'd0, 3'b000, 0, 0, 0, 0, 6, 4'b0010);
        // New issue beats squash and wb on the same rd.
        cyc("iss10",      1, 10, 1, 3, 18'd0, 3'b000, 0, 0, 0, 0, 10, 4'b0100);
        cyc("sq_iss10",   1, 10, 1, 3, 18'd0, 3'b000, 0, 1, 0, 0, 10, 4'b0110);
        cyc("chk10",      0, 0, 0, 0, 18'd0, 3'b000, 0, 0, 0, 0, 10, 4'b0010);
        cyc("iss_wb11",   1, 11, 1, 2, 18'd0, 3'b000, 0, 0, 1, 11, 11, 4'b0100);
        cyc("chk11",      0, 0, 0, 0, 18'd0, 3'b000, 0, 0, 0, 0, 11, 4'b0010);
        // Reset mid-pending with hold and every other input active.
        cyc("iss12",      1, 12, 1, 3, 18'd0, 3'b000, 0, 0, 0, 0, 12, 4'b0100);
        cyc("iss13unk",   1, 13, 1, 15, 18'd0, 3'b000, 0, 0, 0, 0, 12, 4'b0110);
        drive(1, 14, 1, 5, {12'd0, 6'd12}, 3'b001, 1, 1, 1, 13);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("post_rst",   0, 0, 0, 0, 18'd0, 3'b000, 0, 0, 0, 0, -1, 4'b0000);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
